wb_commit: RTL and testbench
============================

# wb_commit

Parametrised multi-lane writeback stage for the dual-issue core. It registers the MEM→WB bundle under the stall/flush protocol and drives the register-file write ports and a pass-through side-band (HI/LO and CP0). It also serialises committed lanes through a trace FIFO onto the single-entry debug trace port, requesting a pipeline stall when the FIFO cannot absorb another bundle.

## Interface
- LANES, 2, issue width (1..4); lane 0 is the older instruction
- SIDE_WD, 180, width of the opaque side-band payload (hilo_bus, cp0 fields, exception info), registered and passed through unchanged
- TRACE_DEPTH, 8, trace FIFO entries; power of two, ≥ 2*LANES
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset; sampled on posedge clk
- flush  in  1  exception/eret flush of this stage
- mem_stall  in  1  MEM stage stopped (stall bit 7)
- wb_stall  in  1  WB stage stopped (stall bit 8)
- lane_valid  in  LANES  lane carries a real instruction
- lane_pc  in  32*LANES  lane PC, lane i at [32i+31:32i]
- lane_we  in  LANES  lane writes a GPR
- lane_waddr  in  5*LANES  destination GPR
- lane_wdata  in  32*LANES  write data
- side_i  in  SIDE_WD  side-band payload
- rf_we  out  LANES  register-file write enables
- rf_waddr  out  5*LANES  register-file write addresses
- rf_wdata  out  32*LANES  register-file write data
- side_o  out  SIDE_WD  registered side-band
- trace_stall_req  out  1  to stall controller: FIFO cannot accept a full bundle
- debug_wb_pc  out  32  traced PC
- debug_wb_rf_wen  out  4  {4{we}} of traced entry
- debug_wb_rf_wnum  out  5  traced GPR
- debug_wb_rf_wdata  out  32  traced data

## Operation
- Pipeline register update priority on each edge: rst low → clear; flush → clear; mem_stall & !wb_stall → clear (bubble); !mem_stall → load inputs; otherwise hold.
- A cleared register has all valid/we bits 0, all fields 0, and side_o = 0.
- rf_we[i] = valid_r[i] & we_r[i] & (waddr_r[i] ≠ 0).
- Intra-bundle WAW: rf_we[i] is forced to 0 when a younger lane j>i in the same bundle also has rf_we[j]=1 to the same address.
- Trace push happens on the same edge as a load, and only on load edges (not on bubble, flush or hold). Each valid lane pushes one entry {pc, we&(waddr≠0), waddr, wdata}, in lane order 0..LANES-1. Lanes with we=0 still push, with wen=0.
- WAW-suppressed lanes are still traced with their own we; the trace reflects architectural order.
- Trace pop: one entry per cycle whenever the FIFO is non-empty. The popped entry is registered onto the debug_* outputs for exactly one cycle.
- When nothing is popped, debug_wb_rf_wen = 0, and pc/wnum/wdata = 0.
- flush does not clear the FIFO: entries already committed still drain. rst clears the FIFO, pointers and count.
- trace_stall_req = (TRACE_DEPTH − count) < 2*LANES. It is combinational from the registered count and sized so that a bundle loaded in the same cycle the request rises cannot overflow.
- count is log2(TRACE_DEPTH)+1 bits. Pointers are log2(TRACE_DEPTH) bits and wrap modulo TRACE_DEPTH. Simultaneous push and pop: count += pushes − 1.
- A push into a full FIFO is a design error; the bench asserts it never occurs.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, side_o=0, all debug_*=0, trace_stall_req=0, count=0.
- rf_* and side_o are valid in the cycle after the load edge. Latency is 1 cycle, fully registered.
- Debug port: the lane-k entry of a bundle loaded at edge T appears after edge T+1+k when the FIFO was empty. Otherwise it appears after all older entries, one per cycle.
- A bundle with no valid lanes pushes nothing.
- Throughput: one bundle per cycle into rf; one trace entry per cycle out. Sustained dual-issue commits therefore raise trace_stall_req periodically.
- rst low mid-operation clears everything on that edge, regardless of flush or stall.

## Test plan
- Reset/idle: hold rst=0 for 2 cycles, then release with no valid lanes → all outputs 0, trace_stall_req=0 for 10 cycles.
- Load at T with lane0 {pc=0xBFC00000, we=1, waddr=8, wdata=0x11} and lane1 {pc=0xBFC00004, we=1, waddr=9, wdata=0x22} → rf_we=2'b11 at T+1. The debug port shows 0xBFC00000/wen=F/8/0x11 at T+2, then 0xBFC00004/9/0x22 at T+3, then wen=0.
- Lane0 and lane1 both write waddr=5 → rf_we=2'b10. Both entries are traced in order with wen=F. A waddr=0 lane gives rf_we=0 and trace wen=0.
- Bubble/flush: mem_stall=1, wb_stall=0 → rf_we=0 next cycle, no push. Flush with 3 entries queued → rf cleared, and 3 entries still drain over the next 3 cycles.
- Back-pressure: LANES=2, DEPTH=8, load valid dual bundles every cycle → trace_stall_req rises when count ≥ 5. Never more than 8 entries. Every pushed PC appears exactly once, in order.
- Hold: mem_stall=1, wb_stall=1 for 4 cycles → rf_* and side_o constant, no pushes, and the FIFO keeps draining.

Source files
------------

// File: rtl/wb_commit.sv
// wb_commit: multi-lane writeback stage.
// Registers the MEM->WB bundle under stall/flush and drives the register-file
// write ports and the side-band. It also serialises committed lanes through a
// trace FIFO onto a single-entry debug port.
//
// Handshake: there is no valid/ready pair here. The stage loads a bundle on any
// edge where rst is high and neither flush nor mem_stall is asserted. The FIFO
// pushes only on such load edges. It pops one entry per edge whenever it is
// non-empty. trace_stall_req asks the stall controller to hold off loads before
// the FIFO could overflow.
module wb_commit #(
  parameter int LANES       = 2,
  parameter int SIDE_WD     = 180,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 mem_stall,
  input  logic                 wb_stall,
  input  logic [LANES-1:0]     lane_valid,
  input  logic [32*LANES-1:0]  lane_pc,
  input  logic [LANES-1:0]     lane_we,
  input  logic [5*LANES-1:0]   lane_waddr,
  input  logic [32*LANES-1:0]  lane_wdata,
  input  logic [SIDE_WD-1:0]   side_i,
  output logic [LANES-1:0]     rf_we,
  output logic [5*LANES-1:0]   rf_waddr,
  output logic [32*LANES-1:0]  rf_wdata,
  output logic [SIDE_WD-1:0]   side_o,
  output logic                 trace_stall_req,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_t;

  // Per-lane views of the flat input buses (lane i sits at the low end for i=0).
  logic [LANES-1:0][31:0] in_pc;
  logic [LANES-1:0][4:0]  in_waddr;
  logic [LANES-1:0][31:0] in_wdata;
  assign in_pc    = lane_pc;
  assign in_waddr = lane_waddr;
  assign in_wdata = lane_wdata;

  // Pipeline register.
  logic [LANES-1:0]       valid_q, valid_d;
  logic [LANES-1:0]       we_q, we_d;
  logic [LANES-1:0][4:0]  waddr_q, waddr_d;
  logic [LANES-1:0][31:0] wdata_q, wdata_d;
  logic [SIDE_WD-1:0]     side_q, side_d;

  logic load;
  assign load = !flush && !mem_stall;

  // Next-state for the pipeline register: flush/bubble clear, load, or hold.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    side_d  = side_q;
    if (flush || (mem_stall && !wb_stall)) begin
      valid_d = '0;
      we_d    = '0;
      waddr_d = '0;
      wdata_d = '0;
      side_d  = '0;
    end else if (!mem_stall) begin
      valid_d = lane_valid;
      we_d    = lane_we;
      waddr_d = in_waddr;
      wdata_d = in_wdata;
      side_d  = side_i;
    end
  end

  // Pipeline register state, with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      side_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      side_q  <= side_d;
    end
  end

  // Write enables. A younger lane writing the same GPR wins, so the older one is dropped.
  logic [LANES-1:0] base_we;
  always_comb begin
    base_we = '0;
    rf_we   = '0;
    for (int i = 0; i < LANES; i++) begin
      base_we[i] = valid_q[i] && we_q[i] && (waddr_q[i] != 5'd0);
    end
    for (int i = 0; i < LANES; i++) begin
      rf_we[i] = base_we[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (base_we[j] && (waddr_q[j] == waddr_q[i])) rf_we[i] = 1'b0;
      end
    end
  end

  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign side_o   = side_q;

  // Trace FIFO.
  trace_t               mem_q [TRACE_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  trace_t               dbg_q;
  logic [LANES-1:0]     push_en;
  logic [LANES-1:0][PW-1:0] slot;
  trace_t [LANES-1:0]   push_entry;
  logic [CW-1:0]        n_push;
  logic                 pop;

  // Pack valid lanes into consecutive FIFO slots, oldest lane first.
  always_comb begin
    n_push     = '0;
    push_en    = '0;
    slot       = '0;
    push_entry = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i]             = wr_ptr_q + n_push[PW-1:0];
      push_en[i]          = rst && load && lane_valid[i];
      push_entry[i].pc    = in_pc[i];
      push_entry[i].wen   = lane_we[i] && (in_waddr[i] != 5'd0);
      push_entry[i].wnum  = in_waddr[i];
      push_entry[i].wdata = in_wdata[i];
      if (push_en[i]) n_push = n_push + CW'(1);
    end
  end

  assign pop = (count_q != '0);

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_en[i]) mem_q[slot[i]] <= push_entry[i];
    end
  end

  // FIFO pointers, occupancy and the one-cycle debug register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dbg_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + n_push[PW-1:0];
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_q + n_push - CW'(pop);
      dbg_q    <= pop ? mem_q[rd_ptr_q] : '0;
    end
  end

  // The threshold keeps room for one whole bundle loaded while the request rises.
  assign trace_stall_req = (TRACE_DEPTH - int'(count_q)) < 2 * LANES;

  assign debug_wb_pc       = dbg_q.pc;
  assign debug_wb_rf_wen   = {4{dbg_q.wen}};
  assign debug_wb_rf_wnum  = dbg_q.wnum;
  assign debug_wb_rf_wdata = dbg_q.wdata;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit (LANES=2, SIDE_WD=180, TRACE_DEPTH=8).
// Register-file and side-band outputs are checked against hand-written values.
// The debug trace port is checked every cycle against an expected-entry queue.
module tb_wb_commit;
  localparam int LANES   = 2;
  localparam int SIDE_WD = 180;
  localparam int DEPTH   = 8;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                flush, mem_stall, wb_stall;
  logic [LANES-1:0]    lane_valid, lane_we;
  logic [32*LANES-1:0] lane_pc, lane_wdata;
  logic [5*LANES-1:0]  lane_waddr;
  logic [SIDE_WD-1:0]  side_i, side_o;
  logic [LANES-1:0]    rf_we;
  logic [5*LANES-1:0]  rf_waddr;
  logic [32*LANES-1:0] rf_wdata;
  logic                trace_stall_req;
  logic [31:0]         debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]          debug_wb_rf_wen;
  logic [4:0]          debug_wb_rf_wnum;

  wb_commit #(.LANES(LANES), .SIDE_WD(SIDE_WD), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem_stall(mem_stall), .wb_stall(wb_stall),
    .lane_valid(lane_valid), .lane_pc(lane_pc), .lane_we(lane_we),
    .lane_waddr(lane_waddr), .lane_wdata(lane_wdata), .side_i(side_i),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .side_o(side_o),
    .trace_stall_req(trace_stall_req), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // Scoreboard state.
  int          checks = 0;
  int          failures = 0;
  logic [72:0] exp_q[$];
  int          ecount = 0;
  logic [72:0] exp_dbg;
  logic [SIDE_WD-1:0] side_a, side_b;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic set_lane(input int i, input logic v, input logic [31:0] pc, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd);
    lane_valid[i]        = v;
    lane_pc[32*i +: 32]  = pc;
    lane_we[i]           = we;
    lane_waddr[5*i +: 5] = wa;
    lane_wdata[32*i +: 32] = wd;
  endtask

  task automatic idle_lanes();
    lane_valid = '0;
    lane_we    = '0;
    lane_pc    = '0;
    lane_waddr = '0;
    lane_wdata = '0;
  endtask

  // One clock: update the trace model from the inputs about to be sampled, then check the debug port.
  task automatic tick();
    int np;
    logic [72:0] e;
    np = 0;
    if (rst && !flush && !mem_stall) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_valid[i]) begin
          e = {lane_pc[32*i +: 32], {4{lane_we[i] && (lane_waddr[5*i +: 5] != 5'd0)}},
               lane_waddr[5*i +: 5], lane_wdata[32*i +: 32]};
          exp_q.push_back(e);
          np++;
        end
      end
    end
    if (!rst) begin
      exp_q.delete();
      ecount  = 0;
      exp_dbg = '0;
    end else if (ecount > 0) begin
      exp_dbg = exp_q.pop_front();
      ecount  = ecount + np - 1;
    end else begin
      exp_dbg = '0;
      ecount  = ecount + np;
    end
    check("fifo_never_overfills", ecount <= DEPTH, 1'b1);
    @(posedge clk);
    #1;
    check("debug_trace", {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}, exp_dbg);
    check("trace_stall_req", trace_stall_req, (DEPTH - ecount) < 2 * LANES);
  endtask

  initial begin
    int stall_cycles;
    logic [31:0] pc;

    // Reset and idle.
    rst = 1'b0; flush = 1'b0; mem_stall = 1'b0; wb_stall = 1'b0;
    side_i = '0;
    idle_lanes();
    side_a = {20'hABCDE, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    side_b = {20'h13579, 32'h2468_ACE0, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    tick();
    tick();
    check("reset_rf_we", rf_we, 2'b00);
    check("reset_rf_waddr", rf_waddr, 10'd0);
    check("reset_rf_wdata", rf_wdata, 64'd0);
    check("reset_side_o", side_o, '0);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_rf_we", rf_we, 2'b00);
    end

    // Dual-issue commit to distinct GPRs.
    side_i = side_a;
    set_lane(0, 1'b1, 32'hBFC0_0000, 1'b1, 5'd8, 32'h11);
    set_lane(1, 1'b1, 32'hBFC0_0004, 1'b1, 5'd9, 32'h22);
    tick();
    idle_lanes();
    check("dual_rf_we", rf_we, 2'b11);
    check("dual_rf_waddr", rf_waddr, {5'd9, 5'd8});
    check("dual_rf_wdata", rf_wdata, {32'h22, 32'h11});
    check("dual_side_o", side_o, side_a);
    tick();
    check("dual_trace0_pc", debug_wb_pc, 32'hBFC0_0000);
    check("dual_trace0_wen", debug_wb_rf_wen, 4'hF);
    check("dual_trace0_wnum", debug_wb_rf_wnum, 5'd8);
    check("dual_trace0_wdata", debug_wb_rf_wdata, 32'h11);
    check("empty_bundle_rf_we", rf_we, 2'b00);
    tick();
    check("dual_trace1_pc", debug_wb_pc, 32'hBFC0_0004);
    check("dual_trace1_wnum", debug_wb_rf_wnum, 5'd9);
    check("dual_trace1_wdata", debug_wb_rf_wdata, 32'h22);
    tick();
    check("trace_idle_wen", debug_wb_rf_wen, 4'h0);
    check("trace_idle_pc", debug_wb_pc, 32'h0);

    // Intra-bundle WAW, r0 writes, and we=0 lanes.
    set_lane(0, 1'b1, 32'h100, 1'b1, 5'd5, 32'hAA);
    set_lane(1, 1'b1, 32'h104, 1'b1, 5'd5, 32'hBB);
    tick();
    check("waw_rf_we", rf_we, 2'b10);
    check("waw_rf_waddr", rf_waddr, {5'd5, 5'd5});
    set_lane(0, 1'b1, 32'h108, 1'b1, 5'd0, 32'h33);
    set_lane(1, 1'b1, 32'h10C, 1'b0, 5'd7, 32'h44);
    tick();
    idle_lanes();
    check("r0_and_nowe_rf_we", rf_we, 2'b00);
    check("waw_trace_old_pc", debug_wb_pc, 32'h100);
    check("waw_trace_old_wen", debug_wb_rf_wen, 4'hF);
    tick();
    check("waw_trace_young_pc", debug_wb_pc, 32'h104);
    check("waw_trace_young_wen", debug_wb_rf_wen, 4'hF);
    tick();
    check("r0_trace_pc", debug_wb_pc, 32'h108);
    check("r0_trace_wen", debug_wb_rf_wen, 4'h0);
    tick();
    check("nowe_trace_wnum", debug_wb_rf_wnum, 5'd7);
    check("nowe_trace_wen", debug_wb_rf_wen, 4'h0);
    set_lane(0, 1'b1, 32'h110, 1'b1, 5'd3, 32'h55);
    set_lane(1, 1'b0, 32'h114, 1'b1, 5'd3, 32'h66);
    tick();
    idle_lanes();
    check("invalid_young_no_waw", rf_we, 2'b01);
    tick();
    tick();

    // Bubble: stalled MEM with running WB inserts an empty bundle and pushes nothing.
    set_lane(0, 1'b1, 32'h200, 1'b1, 5'd1, 32'h201);
    set_lane(1, 1'b1, 32'h204, 1'b1, 5'd2, 32'h205);
    tick();
    check("pre_bubble_rf_we", rf_we, 2'b11);
    mem_stall = 1'b1;
    set_lane(0, 1'b1, 32'h300, 1'b1, 5'd4, 32'h301);
    tick();
    check("bubble_rf_we", rf_we, 2'b00);
    check("bubble_rf_waddr", rf_waddr, 10'd0);
    check("bubble_rf_wdata", rf_wdata, 64'd0);
    mem_stall = 1'b0;
    idle_lanes();
    repeat (3) tick();
    check("bubble_no_push", exp_q.size(), 0);

    // Flush with three entries queued: rf clears, FIFO keeps draining.
    side_i = side_b;
    set_lane(0, 1'b1, 32'h400, 1'b1, 5'd10, 32'h40);
    set_lane(1, 1'b1, 32'h404, 1'b1, 5'd11, 32'h41);
    tick();
    set_lane(0, 1'b1, 32'h408, 1'b1, 5'd12, 32'h42);
    set_lane(1, 1'b1, 32'h40C, 1'b1, 5'd13, 32'h43);
    tick();
    check("pre_flush_rf_we", rf_we, 2'b11);
    flush = 1'b1;
    set_lane(0, 1'b1, 32'h500, 1'b1, 5'd14, 32'h50);
    tick();
    flush = 1'b0;
    idle_lanes();
    check("flush_rf_we", rf_we, 2'b00);
    check("flush_rf_waddr", rf_waddr, 10'd0);
    check("flush_side_o", side_o, '0);
    check("flush_drain0", debug_wb_pc, 32'h404);
    tick();
    check("flush_drain1", debug_wb_pc, 32'h408);
    tick();
    check("flush_drain2", debug_wb_pc, 32'h40C);
    tick();
    check("flush_drained", debug_wb_pc, 32'h0);

    // Hold: both stages stopped, outputs frozen, FIFO drains.
    side_i = side_a;
    set_lane(0, 1'b1, 32'h600, 1'b1, 5'd20, 32'h60);
    set_lane(1, 1'b1, 32'h604, 1'b1, 5'd21, 32'h61);
    tick();
    mem_stall = 1'b1;
    wb_stall  = 1'b1;
    side_i = side_b;
    set_lane(0, 1'b1, 32'h700, 1'b1, 5'd22, 32'h70);
    set_lane(1, 1'b1, 32'h704, 1'b0, 5'd23, 32'h71);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("hold_rf_we", rf_we, 2'b11);
      check("hold_rf_waddr", rf_waddr, {5'd21, 5'd20});
      check("hold_rf_wdata", rf_wdata, {32'h61, 32'h60});
      check("hold_side_o", side_o, side_a);
    end
    mem_stall = 1'b0;
    wb_stall  = 1'b0;
    idle_lanes();
    tick();
    check("hold_no_push", exp_q.size(), 0);

    // Back-pressure: a dual bundle every cycle, with the stall controller obeying trace_stall_req.
    stall_cycles = 0;
    pc = 32'h1000;
    for (int c = 0; c < 40; c++) begin
      mem_stall = trace_stall_req;
      if (trace_stall_req) stall_cycles++;
      set_lane(0, 1'b1, pc, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      set_lane(1, 1'b1, pc + 32'd4, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      tick();
      if (!mem_stall) pc = pc + 32'd8;
    end
    mem_stall = 1'b0;
    idle_lanes();
    repeat (12) tick();
    check("backpressure_stall_seen", stall_cycles > 0, 1'b1);
    check("backpressure_all_drained", exp_q.size(), 0);

    // Reset mid-operation overrides flush and stall.
    set_lane(0, 1'b1, 32'h800, 1'b1, 5'd6, 32'h80);
    set_lane(1, 1'b1, 32'h804, 1'b1, 5'd7, 32'h81);
    tick();
    rst = 1'b0;
    flush = 1'b1;
    mem_stall = 1'b1;
    tick();
    check("midreset_rf_we", rf_we, 2'b00);
    check("midreset_rf_waddr", rf_waddr, 10'd0);
    check("midreset_rf_wdata", rf_wdata, 64'd0);
    check("midreset_side_o", side_o, '0);
    rst = 1'b1;
    flush = 1'b0;
    mem_stall = 1'b0;
    idle_lanes();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
